// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - round-robin arbiter for the instruction memory data port (CPU vs boot loader)
module imem_port_arbiter #(
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        ld_ack,
  output logic [31:0] ld_rdata,
  output logic        ld_err,
  input  logic        ld_boot_done,
  output logic        cpu_hold,
  output logic [31:0] ram_a,
  output logic        wram,
  output logic [31:0] d_t_ram,
  input  logic [31:0] d_f_ram
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LD  = 1'b1;

  state_t      state_q, state_d;
  logic        boot_q, boot_d;
  logic        pending_q, pending_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] ld_rdata_q, ld_rdata_d;
  logic        err_q, err_d;

  logic        addr_valid;
  logic        cpu_elig;
  logic        grant_cpu;

  // Range and alignment check on the latched address
  assign addr_valid = (addr_q[31:ADDR_BITS] == '0) && (addr_q[1:0] == 2'b00);

  // State register; reset puts the block back into BOOT with the loader as last owner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      boot_q       <= 1'b1;
      pending_q    <= 1'b0;
      owner_q      <= OWN_LD;
      last_owner_q <= OWN_LD;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      ld_rdata_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      boot_q       <= boot_d;
      pending_q    <= pending_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ld_rdata_q   <= ld_rdata_d;
      err_q        <= err_d;
    end
  end

  // Next state: grant in IDLE, capture read data in ACCESS, ack in RESP; boot exit only from IDLE
  always_comb begin
    state_d      = state_q;
    boot_d       = boot_q;
    pending_d    = pending_q | (ld_boot_done & boot_q);
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    ld_rdata_d   = ld_rdata_q;
    err_d        = err_q;
    cpu_elig     = cpu_req & ~boot_q;
    grant_cpu    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // boot_q is still high this cycle, so the CPU cannot win until the next IDLE cycle
        if (pending_q) begin
          boot_d    = 1'b0;
          pending_d = 1'b0;
        end
        if (cpu_elig && ld_req) begin
          grant_cpu = (last_owner_q == OWN_LD);
        end else begin
          grant_cpu = cpu_elig;
        end
        if (cpu_elig || ld_req) begin
          owner_d      = grant_cpu ? OWN_CPU : OWN_LD;
          last_owner_d = grant_cpu ? OWN_CPU : OWN_LD;
          we_d         = grant_cpu ? cpu_we : ld_we;
          addr_d       = grant_cpu ? cpu_addr : ld_addr;
          wdata_d      = grant_cpu ? cpu_wdata : ld_wdata;
          state_d      = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (owner_q == OWN_CPU) begin
          cpu_rdata_d = addr_valid ? d_f_ram : 32'h0;
        end else begin
          ld_rdata_d = addr_valid ? d_f_ram : 32'h0;
        end
        err_d   = ~addr_valid;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Memory port and responses are decoded from state so nothing leaks outside ACCESS/RESP
  always_comb begin
    wram      = (state_q == ST_ACCESS) && we_q && addr_valid;
    ram_a     = ((state_q == ST_ACCESS) && addr_valid) ? addr_q : 32'h0;
    d_t_ram   = wram ? wdata_q : 32'h0;
    cpu_ack   = (state_q == ST_RESP) && (owner_q == OWN_CPU);
    ld_ack    = (state_q == ST_RESP) && (owner_q == OWN_LD);
    cpu_err   = cpu_ack & err_q;
    ld_err    = ld_ack & err_q;
    cpu_rdata = cpu_rdata_q;
    ld_rdata  = ld_rdata_q;
    cpu_hold  = boot_q;
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - directed self-checking bench for imem_port_arbiter
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, ld_req, ld_we, ld_boot_done;
  logic [31:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
  logic        cpu_ack, cpu_err, ld_ack, ld_err, cpu_hold, wram;
  logic [31:0] cpu_rdata, ld_rdata, ram_a, d_t_ram, d_f_ram;

  logic        mem_load;
  logic [31:0] mem [0:63];

  int          n_total = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;
  int          ack_seen;

  imem_port_arbiter #(.ADDR_BITS(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .ld_rdata(ld_rdata), .ld_err(ld_err),
    .ld_boot_done(ld_boot_done), .cpu_hold(cpu_hold),
    .ram_a(ram_a), .wram(wram), .d_t_ram(d_t_ram), .d_f_ram(d_f_ram)
  );

  always #5 clk = ~clk;

  assign d_f_ram = mem[ram_a[7:2]];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h3C03C000;
    end else if (wram) begin
      mem[ram_a[7:2]] <= d_t_ram;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mem_load = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0; ld_boot_done = 0;
    cyc(); cyc();
    mem_load = 1'b0; rst = 1'b0;
    cyc();

    // reset state
    check("rst_hold", cpu_hold, 1);
    check("rst_acks", {cpu_ack, ld_ack, cpu_err, ld_err}, 0);
    check("rst_ram_a", ram_a, 0);
    check("rst_wram", wram, 0);
    check("rst_dt", d_t_ram, 0);
    check("rst_rdata", cpu_rdata | ld_rdata, 0);

    // loader write in BOOT mode
    ld_req = 1; ld_we = 1; ld_addr = 32'h10; ld_wdata = 32'hDEADBEEF;
    cyc();
    check("ldw_wram", wram, 1);
    check("ldw_ram_a", ram_a, 32'h10);
    check("ldw_dt", d_t_ram, 32'hDEADBEEF);
    check("ldw_noack", ld_ack, 0);
    cyc();
    check("ldw_ack", ld_ack, 1);
    check("ldw_err", ld_err, 0);
    check("ldw_wram_low", wram, 0);
    check("ldw_hold", cpu_hold, 1);
    ld_req = 0; ld_we = 0;
    cyc();
    check("ldw_ack_drop", ld_ack, 0);
    check("ldw_mem", mem[4], 32'hDEADBEEF);

    // CPU held off in BOOT mode
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0;
    ack_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (cpu_ack || cpu_err || wram) ack_seen++;
    end
    check("boot_no_cpu_ack", ack_seen, 0);
    check("boot_hold", cpu_hold, 1);
    ld_boot_done = 1;
    cyc();
    ld_boot_done = 0;
    check("bd_hold_still", cpu_hold, 1);
    cyc();
    check("bd_hold_low", cpu_hold, 0);
    check("bd_no_ack_yet", cpu_ack, 0);
    cyc();
    check("cpu_rd_access", ram_a, 0);
    cyc();
    check("cpu_rd_ack", cpu_ack, 1);
    check("cpu_rd_data", cpu_rdata, 32'h3C03C000);
    check("cpu_rd_err", cpu_err, 0);
    cpu_req = 0;
    cyc();

    // make the loader last owner, then hold both requests
    ld_req = 1; ld_we = 0; ld_addr = 32'h10;
    cyc(); cyc();
    check("ld_rd_ack", ld_ack, 1);
    check("ld_rd_data", ld_rdata, 32'hDEADBEEF);
    ld_req = 0;
    cyc();
    cpu_req = 1; cpu_addr = 32'h0; ld_req = 1; ld_addr = 32'h10;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check($sformatf("rr_cpu_ack_%0d", k), cpu_ack, (k == 2 || k == 8) ? 1 : 0);
      check($sformatf("rr_ld_ack_%0d", k), ld_ack, (k == 5 || k == 11) ? 1 : 0);
      if (k == 8) check("rr_cpu_data", cpu_rdata, 32'h3C03C000);
      if (k == 11) check("rr_ld_data", ld_rdata, 32'hDEADBEEF);
    end
    cpu_req = 0; ld_req = 0;
    cyc();

    // invalid CPU write then valid read
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h102; cpu_wdata = 32'h12345678;
    cyc();
    check("bad_wram", wram, 0);
    check("bad_ram_a", ram_a, 0);
    cyc();
    check("bad_ack", cpu_ack, 1);
    check("bad_err", cpu_err, 1);
    check("bad_rdata", cpu_rdata, 0);
    cpu_req = 0; cpu_we = 0;
    cyc();
    check("bad_err_clear", cpu_err, 0);
    cpu_req = 1; cpu_addr = 32'h0;
    cyc(); cyc();
    check("ok_ack", cpu_ack, 1);
    check("ok_err", cpu_err, 0);
    check("ok_rdata", cpu_rdata, 32'h3C03C000);
    cpu_req = 0;
    cyc();

    // boot_done during loader ACCESS
    rst = 1; cyc(); rst = 0; cyc();
    check("r2_hold", cpu_hold, 1);
    ld_req = 1; ld_we = 0; ld_addr = 32'h10;
    cyc();
    ld_boot_done = 1;
    cyc();
    ld_boot_done = 0;
    check("bda_ack", ld_ack, 1);
    check("bda_data", ld_rdata, 32'hDEADBEEF);
    check("bda_hold_resp", cpu_hold, 1);
    ld_req = 0;
    cyc();
    check("bda_hold_idle", cpu_hold, 1);
    cyc();
    check("bda_hold_drop", cpu_hold, 0);

    // reset in the middle of a write ACCESS
    ld_req = 1; ld_we = 1; ld_addr = 32'h20; ld_wdata = 32'hA5A5A5A5;
    cyc();
    check("rmid_wram_pre", wram, 1);
    #2 rst = 1;
    #1 check("rmid_wram_async", wram, 0);
    ld_req = 0; ld_we = 0;
    cyc();
    rst = 0;
    ack_seen = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (cpu_ack || ld_ack || wram) ack_seen++;
    end
    check("rmid_no_ack", ack_seen, 0);
    check("rmid_hold", cpu_hold, 1);
    check("rmid_ram_a", ram_a, 0);
    check("rmid_rdata", ld_rdata | cpu_rdata, 0);
    check("rmid_mem", mem[8], 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
